uart_trx: RTL and testbench

Parametrised full-duplex UART transceiver with TX and RX FIFOs. It replaces the bare `uart_tx`/`uart_rx` pair in board-level tops. The user side is a valid/ready byte stream in each direction, and the pin side is a single `rx` input and `tx` output. Adds configurable frame format, FIFO buffering, glitch-rejecting start detection, and framing/overrun reporting.

---
 rtl/uart_trx.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_uart_trx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_trx.sv
// Full-duplex UART transceiver with first-word-fall-through TX/RX FIFOs.
// Define UART_PARITY_EN to add an even-parity bit and the rx_parity_err port.

module uart_trx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == {(AW+1){1'b0}});
  assign full  = (count_q == CNT_FULL);
  assign rdata = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; a pop frees the slot a same-cycle push needs.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = do_pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end
endmodule

module uart_trx #(
  parameter int CLKDIV     = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
`ifdef UART_PARITY_EN
  , output logic               rx_parity_err
`endif
);
  localparam int DIV_W = $clog2(CLKDIV);
  localparam int BIT_W = 4;
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLKDIV / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2, TX_PARITY = 3'd3, TX_STOP = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_WAIT = 3'd0, RX_IDLE = 3'd1, RX_START = 3'd2, RX_DATA = 3'd3, RX_PARITY = 3'd4,
    RX_STOP = 3'd5
  } rx_state_e;

`ifdef UART_PARITY_EN
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
`endif

  // TX side
  tx_state_e            tx_state_q, tx_state_d;
  logic [DIV_W-1:0]     tx_div_q, tx_div_d;
  logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_q, tx_d;
  logic                 tx_pop, tx_tick, tx_empty, tx_full;
  logic [DATA_BITS-1:0] tx_head;
`ifdef UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  uart_trx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_valid), .wdata(tx_data), .pop(tx_pop),
    .rdata(tx_head), .empty(tx_empty), .full(tx_full)
  );

  assign tx_ready = !tx_full;
  assign tx       = tx_q;

  // TX frame sequencer; tx_d is the line level for the bit being entered.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    tx_tick    = (tx_div_q == DIV_LAST);
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      TX_IDLE: begin
        tx_d     = 1'b1;
        tx_div_d = DIV_ZERO;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = tx_head;
`ifdef UART_PARITY_EN
          tx_par_d   = even_parity(tx_head);
`endif
          tx_state_d = TX_START;
          tx_d       = 1'b0;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_div_d   = DIV_ZERO;
          tx_bit_d   = BIT_ZERO;
          tx_state_d = TX_DATA;
          tx_d       = tx_sh_q[0];
        end else begin
          tx_div_d = tx_div_q + DIV_ONE;
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          tx_div_d = DIV_ZERO;
          if (tx_bit_q == DATA_LAST) begin
            tx_bit_d   = BIT_ZERO;
`ifdef UART_PARITY_EN
            tx_state_d = TX_PARITY;
            tx_d       = tx_par_q;
`else
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
`endif
          end else begin
            tx_bit_d = tx_bit_q + BIT_ONE;
            tx_sh_d  = {1'b0, tx_sh_q[DATA_BITS-1:1]};
            tx_d     = tx_sh_q[1];
          end
        end else begin
          tx_div_d = tx_div_q + DIV_ONE;
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (tx_tick) begin
          tx_div_d   = DIV_ZERO;
          tx_bit_d   = BIT_ZERO;
          tx_state_d = TX_STOP;
          tx_d       = 1'b1;
        end else begin
          tx_div_d = tx_div_q + DIV_ONE;
        end
      end
`endif
      TX_STOP: begin
        if (tx_tick) begin
          tx_div_d = DIV_ZERO;
          if (tx_bit_q == STOP_LAST) begin
            // Chain straight into the next start bit when more data is queued.
            if (!tx_empty) begin
              tx_pop     = 1'b1;
              tx_sh_d    = tx_head;
`ifdef UART_PARITY_EN
              tx_par_d   = even_parity(tx_head);
`endif
              tx_state_d = TX_START;
              tx_d       = 1'b0;
            end else begin
              tx_state_d = TX_IDLE;
              tx_d       = 1'b1;
            end
          end else begin
            tx_bit_d = tx_bit_q + BIT_ONE;
            tx_d     = 1'b1;
          end
        end else begin
          tx_div_d = tx_div_q + DIV_ONE;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_d       = 1'b1;
      end
    endcase
  end

  // TX state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_div_q   <= DIV_ZERO;
      tx_bit_q   <= BIT_ZERO;
      tx_sh_q    <= {DATA_BITS{1'b0}};
      tx_q       <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  // RX side
  rx_state_e            rx_state_q, rx_state_d;
  logic [DIV_W-1:0]     rx_div_q, rx_div_d;
  logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic [1:0]           rx_sync_q, rx_sync_d;
  logic                 rx_prev_q, rx_prev_d;
  logic                 frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic                 rx_line, rx_tick, rx_push, rx_pop, rx_empty, rx_full;
`ifdef UART_PARITY_EN
  logic                 rx_par_q, rx_par_d, parity_err_q, parity_err_d;
`endif

  uart_trx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .wdata(rx_sh_q), .pop(rx_ready),
    .rdata(rx_data), .empty(rx_empty), .full(rx_full)
  );

  assign rx_line      = rx_sync_q[1];
  assign rx_valid     = !rx_empty;
  assign rx_pop       = rx_ready && rx_valid;
  assign rx_frame_err = frame_err_q;
  assign rx_overrun   = overrun_q;
`ifdef UART_PARITY_EN
  assign rx_parity_err = parity_err_q;
`endif

  // RX frame sequencer; samples each bit at its centre, counted from the start-bit edge.
  always_comb begin
    rx_sync_d   = {rx_sync_q[0], rx};
    rx_prev_d   = rx_line;
    rx_state_d  = rx_state_q;
    rx_div_d    = rx_div_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_push     = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    rx_tick     = (rx_div_q == DIV_LAST);
`ifdef UART_PARITY_EN
    rx_par_d     = rx_par_q;
    parity_err_d = 1'b0;
`endif
    case (rx_state_q)
      RX_WAIT: begin
        rx_div_d   = DIV_ZERO;
        rx_state_d = rx_line ? RX_IDLE : RX_WAIT;
      end
      RX_IDLE: begin
        rx_div_d   = DIV_ZERO;
        rx_state_d = (rx_prev_q && !rx_line) ? RX_START : RX_IDLE;
      end
      RX_START: begin
        if (rx_div_q == DIV_HALF) begin
          rx_div_d   = DIV_ZERO;
          rx_bit_d   = BIT_ZERO;
          rx_state_d = rx_line ? RX_IDLE : RX_DATA;
        end else begin
          rx_div_d = rx_div_q + DIV_ONE;
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_div_d = DIV_ZERO;
          rx_sh_d  = {rx_line, rx_sh_q[DATA_BITS-1:1]};
          if (rx_bit_q == DATA_LAST) begin
            rx_bit_d   = BIT_ZERO;
`ifdef UART_PARITY_EN
            rx_state_d = RX_PARITY;
`else
            rx_state_d = RX_STOP;
`endif
          end else begin
            rx_bit_d = rx_bit_q + BIT_ONE;
          end
        end else begin
          rx_div_d = rx_div_q + DIV_ONE;
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rx_tick) begin
          rx_div_d   = DIV_ZERO;
          rx_par_d   = rx_line;
          rx_state_d = RX_STOP;
        end else begin
          rx_div_d = rx_div_q + DIV_ONE;
        end
      end
`endif
      RX_STOP: begin
        if (rx_tick) begin
          rx_div_d = DIV_ZERO;
          if (!rx_line) begin
            frame_err_d = 1'b1;
            rx_state_d  = RX_WAIT;
          end else begin
            rx_push      = 1'b1;
            overrun_d    = rx_full && !rx_pop;
`ifdef UART_PARITY_EN
            parity_err_d = rx_par_q ^ even_parity(rx_sh_q);
`endif
            rx_state_d   = RX_IDLE;
          end
        end else begin
          rx_div_d = rx_div_q + DIV_ONE;
        end
      end
      default: begin
        rx_state_d = RX_WAIT;
      end
    endcase
  end

  // RX state registers; synchroniser clears low so a line held low at reset is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q  <= RX_WAIT;
      rx_div_q    <= DIV_ZERO;
      rx_bit_q    <= BIT_ZERO;
      rx_sh_q     <= {DATA_BITS{1'b0}};
      rx_sync_q   <= 2'b00;
      rx_prev_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_q     <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_state_q  <= rx_state_d;
      rx_div_q    <= rx_div_d;
      rx_bit_q    <= rx_bit_d;
      rx_sh_q     <= rx_sh_d;
      rx_sync_q   <= rx_sync_d;
      rx_prev_q   <= rx_prev_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_PARITY_EN
      rx_par_q     <= rx_par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_trx.sv
// Directed bench for uart_trx: CLKDIV=16, 8 data bits, 1 stop bit, 4-entry FIFOs.
module tb_uart_trx;
  localparam int CLKDIV = 16;
`ifdef UART_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS     = 10 + P;
  localparam int FRAME_CYC = CLKDIV * NBITS;
  localparam int PUSH_OFF  = CLKDIV * (9 + P) + CLKDIV / 2 + 3;

  logic       clk = 1'b0;
  logic       rst, tx, tx_valid, tx_ready, rx_valid, rx_ready;
  logic       rx_frame_err, rx_overrun, rx_bb, loop_en;
  logic [7:0] tx_data, rx_data;
  wire        rx_in = loop_en ? tx : rx_bb;
  int         vectors = 0, miscompares = 0;
  int         fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
`ifdef UART_PARITY_EN
  logic       rx_parity_err;
`endif

  always #5 clk = ~clk;

  uart_trx #(.CLKDIV(CLKDIV), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rx(rx_in), .tx(tx),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
`ifdef UART_PARITY_EN
    , .rx_parity_err(rx_parity_err)
`endif
  );

  always @(negedge clk) begin
    if (rx_frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (rx_overrun === 1'b1) ov_cnt <= ov_cnt + 1;
`ifdef UART_PARITY_EN
    if (rx_parity_err === 1'b1) pe_cnt <= pe_cnt + 1;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    else if (idx <= 8) return d[idx-1];
    else if (P == 1 && idx == 9) return ^d;
    else return 1'b1;
  endfunction

  // Push one byte into an idle TX and check every bit at its first and last cycle.
  task automatic tx_frame_check(input logic [7:0] d);
    @(posedge clk); #1 tx_data = d; tx_valid = 1'b1;
    @(posedge clk); #1 tx_valid = 1'b0;
    @(negedge clk); check("tx_high_after_e0", tx, 1);
    @(posedge clk);
    for (int k = 0; k < FRAME_CYC; k++) begin
      @(negedge clk);
      if (k % CLKDIV == 0 || k % CLKDIV == CLKDIV - 1)
        check($sformatf("tx_%0h_bit%0d_cyc%0d", d, k / CLKDIV, k % CLKDIV), tx,
              exp_bit(d, k / CLKDIV));
    end
    @(negedge clk); check("tx_idle_after_frame", tx, 1);
  endtask

  // Drive one frame onto the rx pin, starting just after the next rising edge.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic pflip);
    @(posedge clk); #1 rx_bb = 1'b0;
    repeat (CLKDIV) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx_bb = d[i];
      repeat (CLKDIV) @(posedge clk);
    end
    if (P == 1) begin
      #1 rx_bb = (^d) ^ pflip;
      repeat (CLKDIV) @(posedge clk);
    end
    #1 rx_bb = stop_v;
    repeat (CLKDIV) @(posedge clk);
    #1 rx_bb = 1'b1;
  endtask

  task automatic pop_rx();
    @(posedge clk); #1 rx_ready = 1'b1;
    @(posedge clk); #1 rx_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] lb [3];
    int lows;
    lb = '{8'h00, 8'hFF, 8'hA5};
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
    rx_bb = 1'b1; loop_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_frame_err", rx_frame_err, 0);
    check("rst_overrun", rx_overrun, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Single frame 0x55: latency, bit values, 16-cycle bits, 160-cycle frame.
    tx_frame_check(8'h55);

    // Loopback, three back-to-back frames with no idle gap.
    @(posedge clk); #1 loop_en = 1'b1; tx_data = lb[0]; tx_valid = 1'b1;
    @(posedge clk); #1 tx_data = lb[1];
    @(posedge clk); #1 tx_data = lb[2];
    @(posedge clk); #1 tx_valid = 1'b0;
    for (int k = 2; k < 3 * FRAME_CYC; k++) begin
      @(negedge clk);
      if (k % CLKDIV == CLKDIV / 2)
        check($sformatf("lb_f%0d_bit%0d", k / FRAME_CYC, (k % FRAME_CYC) / CLKDIV), tx,
              exp_bit(lb[k / FRAME_CYC], (k % FRAME_CYC) / CLKDIV));
    end
    repeat (5) @(negedge clk);
    check("lb_valid0", rx_valid, 1);
    check("lb_data0", rx_data, 8'h00);
    pop_rx(); check("lb_data1", rx_data, 8'hFF);
    pop_rx(); check("lb_data2", rx_data, 8'hA5);
    pop_rx(); check("lb_empty", rx_valid, 0);
    check("lb_no_frame_err", fe_cnt, 0);
    check("lb_no_overrun", ov_cnt, 0);
    @(posedge clk); #1 loop_en = 1'b0;

    // Stop bit low, then a good frame, then a short glitch.
    repeat (5) @(posedge clk);
    send_frame(8'h81, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("ferr_count", fe_cnt, 1);
    check("ferr_no_valid", rx_valid, 0);
    repeat (20) @(posedge clk);
    send_frame(8'h3C, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check("after_ferr_valid", rx_valid, 1);
    check("after_ferr_data", rx_data, 8'h3C);
    pop_rx(); check("after_ferr_empty", rx_valid, 0);
    @(posedge clk); #1 rx_bb = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_bb = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_no_valid", rx_valid, 0);
    check("glitch_no_err", fe_cnt, 1);

    // Overrun: five frames into a 4-entry FIFO with no consumer.
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    send_frame(8'h33, 1'b1, 1'b0);
    send_frame(8'h44, 1'b1, 1'b0);
    @(negedge clk); check("ovr_none_at4", ov_cnt, 0);
    send_frame(8'h55, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    check("ovr_once", ov_cnt, 1);
    check("ovr_d0", rx_data, 8'h11);
    pop_rx(); check("ovr_d1", rx_data, 8'h22);
    pop_rx(); check("ovr_d2", rx_data, 8'h33);
    pop_rx(); check("ovr_d3", rx_data, 8'h44);
    pop_rx(); check("ovr_empty", rx_valid, 0);

    // Pop coinciding with the push of a fifth frame into a full FIFO.
    send_frame(8'h61, 1'b1, 1'b0);
    send_frame(8'h62, 1'b1, 1'b0);
    send_frame(8'h63, 1'b1, 1'b0);
    send_frame(8'h64, 1'b1, 1'b0);
    fork
      send_frame(8'h65, 1'b1, 1'b0);
      begin
        @(posedge clk); #1;
        repeat (PUSH_OFF - 1) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk); #1 rx_ready = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    check("simul_no_overrun", ov_cnt, 1);
    check("simul_d0", rx_data, 8'h62);
    pop_rx(); check("simul_d1", rx_data, 8'h63);
    pop_rx(); check("simul_d2", rx_data, 8'h64);
    pop_rx(); check("simul_d3", rx_data, 8'h65);
    pop_rx(); check("simul_empty", rx_valid, 0);

    // Reset in the middle of a TX data bit with the FIFO full.
    @(posedge clk); #1 tx_data = 8'h00; tx_valid = 1'b1;
    for (int i = 1; i < 5; i++) begin
      @(posedge clk); #1 tx_data = 8'(i);
    end
    @(posedge clk); #1 tx_valid = 1'b0;
    @(negedge clk); check("txrst_full", tx_ready, 0);
    repeat (40) @(posedge clk);
    @(negedge clk); check("txrst_low_before", tx, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("txrst_tx_high", tx, 1);
    check("txrst_ready", tx_ready, 1);
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("txrst_fifo_empty", lows, 0);

    // Reset released while rx is held low.
    @(posedge clk); #1 rx_bb = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (200) @(posedge clk);
    #1 rx_bb = 1'b1;
    repeat (20) @(negedge clk);
    check("rxlow_no_err", fe_cnt, 1);
    check("rxlow_no_valid", rx_valid, 0);
    send_frame(8'hC3, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check("rxlow_then_valid", rx_valid, 1);
    check("rxlow_then_data", rx_data, 8'hC3);
    pop_rx();

`ifdef UART_PARITY_EN
    tx_frame_check(8'h07);
    send_frame(8'h5A, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check("par_err_once", pe_cnt, 1);
    check("par_valid", rx_valid, 1);
    check("par_data", rx_data, 8'h5A);
    pop_rx();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
